// File: rtl/pipe_ctrl.sv
// Pipeline hazard and data-memory handshake controller.
// Memory FSM stalls the whole pipe; load-use and branch rules act otherwise.
module pipe_ctrl #(
  parameter int TIMEOUT_CYC = 255,
  parameter int CNT_W       = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        readm,
  input  logic        memWrtm,
  input  logic        dmem_ack,
  input  logic        reade,
  input  logic [4:0]  rde,
  input  logic [4:0]  rs1d,
  input  logic [4:0]  rs2d,
  input  logic        pcSrce,
  output logic        dmem_req,
  output logic        dmem_err,
  output logic        enf_n,
  output logic        end_n,
  output logic        ene_n,
  output logic        enm_n,
  output logic        enw_n,
  output logic        flushd,
  output logic        flushe,
  output logic [15:0] stall_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE,
    ERR
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             memop;
  logic             mstall;
  logic             luse;
  logic             hold;
  logic             br;
  logic             ld;

  assign memop  = readm | memWrtm;
  assign mstall = (state == IDLE && memop)
                | (state == WAIT)
                | (state == ERR);
  assign luse   = reade && (rde != 5'd0)
               && (rde == rs1d || rde == rs2d);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      dmem_req <= 1'b0;
      dmem_err <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (memop) begin
            state    <= WAIT;
            cnt      <= '0;
            dmem_req <= 1'b1;
          end
        end
        WAIT: begin
          // ack takes priority over an expiring timeout
          if (dmem_ack) begin
            state    <= DONE;
            dmem_req <= 1'b0;
          end else if (cnt == CNT_W'(TIMEOUT_CYC)) begin
            state    <= ERR;
            dmem_req <= 1'b0;
            dmem_err <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: state <= IDLE;
        ERR:  state <= ERR;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cnt <= '0;
    else if (mstall && stall_cnt != 16'hFFFF)
      stall_cnt <= stall_cnt + 16'd1;
  end

  assign hold = !rst_n || mstall;
  assign br   = !hold && pcSrce;
  assign ld   = !hold && !pcSrce && luse;

  always_comb begin
    enf_n  = 1'b0;
    end_n  = 1'b0;
    ene_n  = 1'b0;
    enm_n  = 1'b0;
    enw_n  = 1'b0;
    flushd = 1'b0;
    flushe = 1'b0;
    unique case (1'b1)
      hold: begin
        enf_n = 1'b1;
        end_n = 1'b1;
        ene_n = 1'b1;
        enm_n = 1'b1;
        enw_n = 1'b1;
      end
      br: begin
        flushd = 1'b1;
        flushe = 1'b1;
      end
      ld: begin
        enf_n  = 1'b1;
        end_n  = 1'b1;
        flushe = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed and random checks of pipe_ctrl against a transaction-level model.
// Inputs change after negedge; outputs are sampled 1 ns later.
module tb_pipe_ctrl;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        readm = 1'b0, memWrtm = 1'b0, dmem_ack = 1'b0;
  logic        reade = 1'b0, pcSrce = 1'b0;
  logic [4:0]  rde = '0, rs1d = '0, rs2d = '0;
  logic        dmem_req, dmem_err;
  logic        enf_n, end_n, ene_n, enm_n, enw_n;
  logic        flushd, flushe;
  logic [15:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  bit m_fail;
  bit m_done;
  int m_age;
  int m_stall;

  pipe_ctrl #(.TIMEOUT_CYC(TO), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .readm(readm), .memWrtm(memWrtm), .dmem_ack(dmem_ack),
    .reade(reade), .rde(rde), .rs1d(rs1d), .rs2d(rs2d),
    .pcSrce(pcSrce),
    .dmem_req(dmem_req), .dmem_err(dmem_err),
    .enf_n(enf_n), .end_n(end_n), .ene_n(ene_n),
    .enm_n(enm_n), .enw_n(enw_n),
    .flushd(flushd), .flushe(flushe),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  function automatic void m_reset();
    m_fail  = 1'b0;
    m_done  = 1'b0;
    m_age   = -1;
    m_stall = 0;
  endfunction

  function automatic bit m_mstall();
    bit memop = readm || memWrtm;
    return m_fail || m_age >= 0 || (!m_done && memop);
  endfunction

  function automatic void m_update();
    bit mst = m_mstall();
    if (mst && m_stall < 65535) m_stall++;
    if (m_fail) begin
    end else if (m_age >= 0) begin
      if (dmem_ack) begin
        m_done = 1'b1;
        m_age  = -1;
      end else if (m_age == TO) begin
        m_fail = 1'b1;
        m_age  = -1;
      end else begin
        m_age++;
      end
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (readm || memWrtm) begin
      m_age = 0;
    end
  endfunction

  task automatic check(input string tag);
    logic [4:0] xen;
    logic [1:0] xfl;
    bit luse;
    luse = reade && rde != 0 && (rde == rs1d || rde == rs2d);
    if (!rst_n || m_mstall()) begin
      xen = 5'b11111; xfl = 2'b00;
    end else if (pcSrce) begin
      xen = 5'b00000; xfl = 2'b11;
    end else if (luse) begin
      xen = 5'b11000; xfl = 2'b01;
    end else begin
      xen = 5'b00000; xfl = 2'b00;
    end
    checks++;
    assert ({enf_n, end_n, ene_n, enm_n, enw_n} === xen)
    else begin
      errors++;
      $error("FAIL %s en_n got %b want %b", tag,
             {enf_n, end_n, ene_n, enm_n, enw_n}, xen);
    end
    checks++;
    assert ({flushd, flushe} === xfl)
    else begin
      errors++;
      $error("FAIL %s flush got %b want %b", tag,
             {flushd, flushe}, xfl);
    end
    checks++;
    assert (dmem_req === (m_age >= 0))
    else begin
      errors++;
      $error("FAIL %s dmem_req got %b want %b", tag,
             dmem_req, m_age >= 0);
    end
    checks++;
    assert (dmem_err === m_fail)
    else begin
      errors++;
      $error("FAIL %s dmem_err got %b want %b", tag,
             dmem_err, m_fail);
    end
    checks++;
    assert (stall_cnt === 16'(m_stall))
    else begin
      errors++;
      $error("FAIL %s stall_cnt got %0d want %0d", tag,
             stall_cnt, m_stall);
    end
  endtask

  task automatic cycle(input string tag, input bit chk = 1'b1);
    #1;
    if (chk) check(tag);
    @(posedge clk);
    if (rst_n) m_update();
    @(negedge clk);
  endtask

  task automatic set_in(input bit r, input bit w, input bit a,
                        input bit re, input int rd, input int s1,
                        input int s2, input bit pc);
    readm = r; memWrtm = w; dmem_ack = a; reade = re;
    rde = 5'(rd); rs1d = 5'(s1); rs2d = 5'(s2); pcSrce = pc;
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    m_reset();
    cycle(tag);
    rst_n = 1'b1;
  endtask

  initial begin
    m_reset();
    @(negedge clk);
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    do_reset("reset");

    // load: request at cycle 0, ack at cycle 3, DONE at cycle 4
    set_in(1, 0, 0, 0, 0, 0, 0, 0); cycle("ld_c0");
    set_in(0, 0, 0, 0, 0, 0, 0, 0); cycle("ld_c1");
    cycle("ld_c2");
    set_in(0, 0, 1, 0, 0, 0, 0, 0); cycle("ld_c3");
    set_in(1, 0, 0, 0, 0, 0, 0, 0);
    #1;
    checks++;
    assert (stall_cnt === 16'd4 && enf_n === 1'b0 && !dmem_req)
    else begin
      errors++;
      $error("FAIL done_c4 stall_cnt got %0d want 4 enf_n %b req %b",
             stall_cnt, enf_n, dmem_req);
    end
    cycle("ld_c4_done");
    set_in(0, 0, 0, 0, 0, 0, 0, 0); cycle("idle_after");

    // store that never completes -> ERR
    do_reset("rst2");
    set_in(0, 1, 0, 0, 0, 0, 0, 0); cycle("st_req");
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < TO + 1; i++) cycle("st_wait");
    set_in(0, 0, 1, 0, 0, 0, 0, 1); cycle("err_ack_ign");
    checks++;
    assert (dmem_err === 1'b1 && dmem_req === 1'b0)
    else begin
      errors++;
      $error("FAIL err_flag got err %b req %b want 1 0",
             dmem_err, dmem_req);
    end
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 65540; i++) cycle("err_sat", 1'b0);
    cycle("err_saturated");
    do_reset("err_clear");

    // load-use, rde=0, branch over load-use
    set_in(0, 0, 0, 1, 5, 0, 5, 0); cycle("luse_rs2");
    set_in(0, 0, 0, 1, 7, 7, 1, 0); cycle("luse_rs1");
    set_in(0, 0, 0, 1, 0, 0, 0, 0); cycle("luse_r0");
    set_in(0, 0, 0, 0, 5, 5, 5, 0); cycle("no_load");
    set_in(0, 0, 0, 1, 5, 0, 5, 1); cycle("br_luse");

    // branch while waiting; ack coinciding with timeout
    set_in(1, 0, 0, 0, 0, 0, 0, 1); cycle("br_req");
    for (int i = 0; i < TO; i++) cycle("br_wait");
    set_in(0, 0, 1, 0, 0, 0, 0, 1); cycle("ack_at_to");
    set_in(0, 1, 0, 0, 0, 0, 0, 1); cycle("done_br");
    checks++;
    assert (dmem_err === 1'b0)
    else begin
      errors++;
      $error("FAIL ack_wins dmem_err got %b want 0", dmem_err);
    end

    // reset pulse mid-WAIT
    set_in(1, 0, 0, 0, 0, 0, 0, 0); cycle("mid_req");
    set_in(0, 0, 0, 0, 0, 0, 0, 0); cycle("mid_wait");
    do_reset("mid_rst");
    cycle("post_rst");

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        do_reset("rnd_rst");
      end else begin
        set_in($urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0,
               $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
               $urandom_range(0, 3), $urandom_range(0, 3),
               $urandom_range(0, 3), $urandom_range(0, 4) == 0);
        cycle("rnd");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
